acc_io_bridge: RTL and testbench

//   Host-side end of the accumulator CPU's 16-bit IO port: feeds IOIn, consumes Output.
//   - RX path: host pushes 16-bit words (valid/ready) into an RX FIFO; CPU sees the

---
 rtl/acc_io_pkg.sv | 8 +
 rtl/acc_io_fifo.sv | 61 ++++++
 rtl/acc_io_bridge.sv | 86 ++++++++
 tb/tb_acc_io_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_io_pkg.sv
// Shared widths and default sizing for the accumulator CPU host IO bridge.
package acc_io_pkg;
    localparam int IO_W  = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef logic [IO_W-1:0] io_word_t;
endpackage

// File: rtl/acc_io_fifo.sv
// First-word-fall-through FIFO; a push at edge N is visible on dout after edge N.
// Push is ignored while full and pop is ignored while empty (both judged on pre-edge state).
module acc_io_fifo
    import acc_io_pkg::IO_W;
#(
    parameter int DEPTH = acc_io_pkg::DEPTH,
    parameter int AW    = acc_io_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [IO_W-1:0] din,
    output logic [IO_W-1:0] dout,
    output logic            full,
    output logic            empty
);

    logic [IO_W-1:0] mem_q [DEPTH];
    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic            do_push;
    logic            do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= din;
            end
        end
    end

    assign dout = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/acc_io_bridge.sv
// Host-side IO port of the accumulator CPU: RX FIFO feeds IOIn, TX FIFO drains Output.
// One cycle push-to-visible latency; host sees ready/valid, CPU drops writes on TX full.
module acc_io_bridge
    import acc_io_pkg::IO_W;
#(
    parameter int DEPTH = acc_io_pkg::DEPTH,
    parameter int AW    = acc_io_pkg::AW
) (
    input  logic            CLK,
    input  logic            reset,
    output logic [IO_W-1:0] cpu_io_in,
    input  logic            cpu_rd,
    input  logic [IO_W-1:0] cpu_io_out,
    input  logic            cpu_wr,
    output logic            rx_avail,
    input  logic [IO_W-1:0] host_in_data,
    input  logic            host_in_valid,
    output logic            host_in_ready,
    output logic [IO_W-1:0] host_out_data,
    output logic            host_out_valid,
    input  logic            host_out_ready,
    input  logic            err_clr,
    output logic            tx_ovf,
    output logic            rx_udf
);

    logic [IO_W-1:0] rx_dout, tx_dout;
    logic            rx_full, rx_empty;
    logic            tx_full, tx_empty;
    logic            tx_ovf_q, tx_ovf_d;
    logic            rx_udf_q, rx_udf_d;

    acc_io_fifo #(.DEPTH(DEPTH), .AW(AW)) rx_fifo (
        .clk   (CLK),
        .rst   (reset),
        .push  (host_in_valid),
        .pop   (cpu_rd),
        .din   (host_in_data),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    acc_io_fifo #(.DEPTH(DEPTH), .AW(AW)) tx_fifo (
        .clk   (CLK),
        .rst   (reset),
        .push  (cpu_wr),
        .pop   (host_out_ready),
        .din   (cpu_io_out),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign rx_avail       = !rx_empty;
    assign host_in_ready  = !rx_full;
    assign host_out_valid = !tx_empty;
    assign cpu_io_in      = rx_empty ? '0 : rx_dout;
    assign host_out_data  = tx_empty ? '0 : tx_dout;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        tx_ovf_d = tx_ovf_q && !err_clr;
        rx_udf_d = rx_udf_q && !err_clr;
        if (cpu_wr && tx_full) begin
            tx_ovf_d = 1'b1;
        end
        if (cpu_rd && rx_empty) begin
            rx_udf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
        end
    end

    assign tx_ovf = tx_ovf_q;
    assign rx_udf = rx_udf_q;

endmodule

// File: tb/tb_acc_io_bridge.sv
// Directed, table-driven bench for acc_io_bridge with hand-written multi-cycle sequences.
module tb_acc_io_bridge;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] cpu_io_in;
    logic        cpu_rd;
    logic [15:0] cpu_io_out;
    logic        cpu_wr;
    logic        rx_avail;
    logic [15:0] host_in_data;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [15:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready;
    logic        err_clr;
    logic        tx_ovf;
    logic        rx_udf;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    acc_io_bridge dut (
        .CLK            (CLK),
        .reset          (reset),
        .cpu_io_in      (cpu_io_in),
        .cpu_rd         (cpu_rd),
        .cpu_io_out     (cpu_io_out),
        .cpu_wr         (cpu_wr),
        .rx_avail       (rx_avail),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .err_clr        (err_clr),
        .tx_ovf         (tx_ovf),
        .rx_udf         (rx_udf)
    );

    typedef struct packed {
        logic [15:0] io_in;
        logic        avail;
        logic        hin_rdy;
        logic [15:0] hout_dat;
        logic        hout_vld;
        logic        ovf;
        logic        udf;
    } outs_t;

    typedef struct {
        logic        hiv;
        logic [15:0] hid;
        logic        rd;
        logic        wr;
        logic [15:0] wd;
        logic        hor;
        logic        clr;
        outs_t       exp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic hiv, input logic [15:0] hid, input logic rd,
                                input logic wr, input logic [15:0] wd, input logic hor,
                                input logic clr, input logic [15:0] eio, input logic eav,
                                input logic ehir, input logic [15:0] ehod, input logic ehov,
                                input logic eovf, input logic eudf);
        vec_t v;
        v.hiv = hiv; v.hid = hid; v.rd = rd; v.wr = wr; v.wd = wd; v.hor = hor; v.clr = clr;
        v.exp = '{io_in: eio, avail: eav, hin_rdy: ehir, hout_dat: ehod,
                  hout_vld: ehov, ovf: eovf, udf: eudf};
        return v;
    endfunction

    function automatic outs_t cur_outs();
        outs_t o;
        o = '{io_in: cpu_io_in, avail: rx_avail, hin_rdy: host_in_ready,
              hout_dat: host_out_data, hout_vld: host_out_valid, ovf: tx_ovf, udf: rx_udf};
        return o;
    endfunction

    task automatic chk_o(input string name, input outs_t act, input outs_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (io_in,avail,hin_rdy,hout_dat,hout_vld,ovf,udf)",
                     name, act, req);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic idle();
        host_in_valid  = 1'b0;
        host_in_data   = 16'h0;
        cpu_rd         = 1'b0;
        cpu_wr         = 1'b0;
        cpu_io_out     = 16'h0;
        host_out_ready = 1'b0;
        err_clr        = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        outs_t rst_exp;
        int    sent;
        int    got;
        int    occ;
        int    cyc;
        logic  wr_now;
        logic  pop_now;

        rst_exp = '{io_in: 16'h0, avail: 1'b0, hin_rdy: 1'b1, hout_dat: 16'h0,
                    hout_vld: 1'b0, ovf: 1'b0, udf: 1'b0};

        idle();
        reset = 1'b1;
        #12;
        chk_o("reset_state", cur_outs(), rst_exp);
        reset = 1'b0;
        tick();

        //            hiv   hid       rd    wr    wd        hor   clr   io_in     av    hir   hod       hov   ovf   udf
        vq.push_back(mk(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hABCD, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'h3333, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'h4444, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h2222, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h2222, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h3333, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4444, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'h00AA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h00AA, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'h00BB, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h00BB, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 16'h00CC, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h00CC, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h8888, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h8888, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));

        foreach (vq[i]) begin
            host_in_valid  = vq[i].hiv;
            host_in_data   = vq[i].hid;
            cpu_rd         = vq[i].rd;
            cpu_wr         = vq[i].wr;
            cpu_io_out     = vq[i].wd;
            host_out_ready = vq[i].hor;
            err_clr        = vq[i].clr;
            tick();
            chk_o($sformatf("vec%0d", i), cur_outs(), vq[i].exp);
        end
        idle();

        // TX overflow: fifth write into a full TX is dropped.
        for (int i = 1; i <= 5; i++) begin
            cpu_wr     = 1'b1;
            cpu_io_out = 16'(i);
            tick();
            if (i == 4) chk("tx_ovf_at_full", 32'(tx_ovf), 32'd0);
        end
        cpu_wr = 1'b0;
        chk("tx_ovf_set", 32'(tx_ovf), 32'd1);
        host_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tx_drain%0d", i), 32'(host_out_data), 32'(i));
            tick();
        end
        host_out_ready = 1'b0;
        chk("tx_drained_vld", 32'(host_out_valid), 32'd0);
        chk("tx_ovf_held", 32'(tx_ovf), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tx_ovf_clr", 32'(tx_ovf), 32'd0);

        // Wrap: 20 words through TX, host ready toggling, CPU writes only when space remains.
        sent = 0;
        got  = 0;
        occ  = 0;
        cyc  = 0;
        host_out_ready = 1'b0;
        while (got < 20 && cyc < 200) begin
            chk("wrap_vld", 32'(host_out_valid), 32'(occ > 0));
            host_out_ready = ~host_out_ready;
            pop_now = host_out_ready && (occ > 0);
            wr_now  = (sent < 20) && (occ < 4);
            if (pop_now) begin
                chk($sformatf("wrap_word%0d", got), 32'(host_out_data), 32'h0100 + 32'(got));
                got++;
            end
            cpu_wr     = wr_now;
            cpu_io_out = 16'h0100 + 16'(sent);
            if (wr_now) sent++;
            occ = occ + (wr_now ? 1 : 0) - (pop_now ? 1 : 0);
            tick();
            cyc++;
        end
        idle();
        chk("wrap_count", 32'(got), 32'd20);
        chk("wrap_ovf", 32'(tx_ovf), 32'd0);

        // Async reset mid-transfer, asserted between clock edges.
        host_in_valid = 1'b1;
        host_in_data  = 16'hDEAD;
        cpu_wr        = 1'b1;
        cpu_io_out    = 16'hBEEF;
        tick();
        idle();
        cpu_rd = 1'b1;
        host_in_valid = 1'b0;
        tick();
        cpu_rd = 1'b0;
        cpu_wr = 1'b1;
        cpu_io_out = 16'hBEEF;
        tick();
        idle();
        chk("pre_reset_tx_vld", 32'(host_out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_o("async_reset", cur_outs(), rst_exp);
        #2;
        reset = 1'b0;
        tick();
        chk_o("post_reset", cur_outs(), rst_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
